// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - BMP frame read sequencer producing a tagged 24-bit pixel stream
module frame_sequencer #(
    parameter int                   ADDR_BITS = 24,
    parameter int                   DIM_BITS  = 12,
    parameter logic [ADDR_BITS-1:0] BASE_ADDR = '0
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic [DIM_BITS-1:0]  width_i,
    input  logic [DIM_BITS-1:0]  height_i,
    output logic                 mem_rd_en_o,
    output logic [ADDR_BITS-1:0] mem_addr_o,
    input  logic [7:0]           mem_rd_data_i,
    output logic                 pix_valid_o,
    input  logic                 pix_ready_i,
    output logic [23:0]          pix_data_o,
    output logic [DIM_BITS-1:0]  pix_x_o,
    output logic [DIM_BITS-1:0]  pix_y_o,
    output logic                 sof_o,
    output logic                 eol_o,
    output logic                 eof_o,
    output logic                 busy_o,
    output logic                 done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LAST,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t                 state_q;
    logic [1:0]             byte_idx_q;
    logic [DIM_BITS-1:0]    width_q;
    logic [DIM_BITS-1:0]    height_q;
    logic [DIM_BITS-1:0]    x_q;
    logic [DIM_BITS-1:0]    y_q;
    logic [ADDR_BITS-1:0]   row_base_q;
    logic [ADDR_BITS-1:0]   stride_q;
    logic                   mem_rd_en_q;
    logic [ADDR_BITS-1:0]   mem_addr_q;
    logic                   pix_valid_q;
    logic [23:0]            pix_data_q;
    logic                   sof_q;
    logic                   eol_q;
    logic                   eof_q;
    logic                   busy_q;
    logic                   done_q;

    // Row stride: 3 bytes per pixel rounded up to a 4-byte boundary (BMP row padding)
    logic [ADDR_BITS-1:0]   width_ext;
    logic [ADDR_BITS-1:0]   stride_d;
    logic                   last_col;
    logic                   last_row;
    logic                   dims_ok;

    assign width_ext = ADDR_BITS'(width_i);
    assign stride_d  = (width_ext + (width_ext << 1) + ADDR_BITS'(3)) & ~ADDR_BITS'(3);
    assign last_col  = (x_q == width_q - 1'b1);
    assign last_row  = (y_q == height_q - 1'b1);
    assign dims_ok   = (width_i != '0) && (height_i != '0);

    // Frame walk FSM: three byte reads, one capture cycle, then hold the pixel until accepted
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            byte_idx_q  <= '0;
            width_q     <= '0;
            height_q    <= '0;
            x_q         <= '0;
            y_q         <= '0;
            row_base_q  <= '0;
            stride_q    <= '0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
            eof_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        if (dims_ok) begin
                            width_q     <= width_i;
                            height_q    <= height_i;
                            stride_q    <= stride_d;
                            row_base_q  <= BASE_ADDR;
                            x_q         <= '0;
                            y_q         <= '0;
                            busy_q      <= 1'b1;
                            mem_rd_en_q <= 1'b1;
                            mem_addr_q  <= BASE_ADDR;
                            byte_idx_q  <= 2'd0;
                            state_q     <= S_READ;
                        end else begin
                            // Degenerate frame: report completion without touching memory
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_READ: begin
                    case (byte_idx_q)
                        2'd0: begin
                            mem_addr_q <= mem_addr_q + 1'b1;
                            byte_idx_q <= 2'd1;
                        end
                        2'd1: begin
                            pix_data_q[7:0] <= mem_rd_data_i;
                            mem_addr_q      <= mem_addr_q + 1'b1;
                            byte_idx_q      <= 2'd2;
                        end
                        default: begin
                            pix_data_q[15:8] <= mem_rd_data_i;
                            mem_rd_en_q      <= 1'b0;
                            state_q          <= S_LAST;
                        end
                    endcase
                end
                S_LAST: begin
                    pix_data_q[23:16] <= mem_rd_data_i;
                    pix_valid_q       <= 1'b1;
                    sof_q             <= (x_q == '0) && (y_q == '0);
                    eol_q             <= last_col;
                    eof_q             <= last_col && last_row;
                    state_q           <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (pix_ready_i) begin
                        pix_valid_q <= 1'b0;
                        sof_q       <= 1'b0;
                        eol_q       <= 1'b0;
                        eof_q       <= 1'b0;
                        if (eof_q) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else if (eol_q) begin
                            x_q         <= '0;
                            y_q         <= y_q + 1'b1;
                            row_base_q  <= row_base_q + stride_q;
                            mem_addr_q  <= row_base_q + stride_q;
                            mem_rd_en_q <= 1'b1;
                            byte_idx_q  <= 2'd0;
                            state_q     <= S_READ;
                        end else begin
                            // Pixels are contiguous within a row: next byte follows the last one read
                            x_q         <= x_q + 1'b1;
                            mem_addr_q  <= mem_addr_q + 1'b1;
                            mem_rd_en_q <= 1'b1;
                            byte_idx_q  <= 2'd0;
                            state_q     <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_rd_en_o = mem_rd_en_q;
    assign mem_addr_o  = mem_addr_q;
    assign pix_valid_o = pix_valid_q;
    assign pix_data_o  = pix_data_q;
    assign pix_x_o     = x_q;
    assign pix_y_o     = y_q;
    assign sof_o       = sof_q;
    assign eol_o       = eol_q;
    assign eof_o       = eof_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - scoreboard bench for frame_sequencer
module tb_frame_sequencer;

    localparam int AB = 24;
    localparam int DB = 12;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          start_i;
    logic [DB-1:0] width_i;
    logic [DB-1:0] height_i;
    logic          mem_rd_en_o;
    logic [AB-1:0] mem_addr_o;
    logic [7:0]    mem_rd_data_i;
    logic          pix_valid_o;
    logic          pix_ready_i;
    logic [23:0]   pix_data_o;
    logic [DB-1:0] pix_x_o;
    logic [DB-1:0] pix_y_o;
    logic          sof_o, eol_o, eof_o, busy_o, done_o;

    frame_sequencer #(.ADDR_BITS(AB), .DIM_BITS(DB), .BASE_ADDR('0)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i),
        .width_i(width_i), .height_i(height_i),
        .mem_rd_en_o(mem_rd_en_o), .mem_addr_o(mem_addr_o), .mem_rd_data_i(mem_rd_data_i),
        .pix_valid_o(pix_valid_o), .pix_ready_i(pix_ready_i), .pix_data_o(pix_data_o),
        .pix_x_o(pix_x_o), .pix_y_o(pix_y_o), .sof_o(sof_o), .eol_o(eol_o), .eof_o(eof_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [23:0]   data;
        logic [DB-1:0] x;
        logic [DB-1:0] y;
        logic          sof;
        logic          eol;
        logic          eof;
    } pix_t;

    pix_t         pix_q[$];
    logic [AB-1:0] rd_q[$];
    int           exp_done;
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           reads_seen = 0;
    int           last_hs_cyc = -100;
    int           ready_mode = 0;

    function automatic logic [7:0] mem_f(input logic [AB-1:0] a);
        return (8'(a) + 8'd1) ^ 8'(a >> 8);
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        mem_rd_data_i <= mem_rd_en_o ? mem_f(mem_addr_o) : 8'($urandom);
    end

    // Reference model: row-major walk, BMP rows padded to multiples of 4 bytes
    task automatic model_frame(input int w, input int h);
        int stride;
        stride = ((3 * w + 3) / 4) * 4;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                pix_t p;
                logic [AB-1:0] a;
                a = AB'(y * stride + 3 * x);
                rd_q.push_back(a);
                rd_q.push_back(a + 1);
                rd_q.push_back(a + 2);
                p.data = {mem_f(a + 2), mem_f(a + 1), mem_f(a)};
                p.x    = DB'(x);
                p.y    = DB'(y);
                p.sof  = (x == 0) && (y == 0);
                p.eol  = (x == w - 1);
                p.eof  = (x == w - 1) && (y == h - 1);
                pix_q.push_back(p);
            end
        end
    endtask

    // Downstream ready generator
    initial begin
        int stall;
        stall = 0;
        pix_ready_i = 1'b1;
        forever begin
            tick();
            case (ready_mode)
                0: pix_ready_i = 1'b1;
                1: pix_ready_i = ($urandom_range(0, 3) != 0);
                default: begin
                    if (pix_valid_o && stall < 3) begin
                        pix_ready_i = 1'b0;
                        stall++;
                    end else begin
                        pix_ready_i = 1'b1;
                        if (!pix_valid_o) stall = 0;
                    end
                end
            endcase
        end
    end

    // Monitor: reads, pixels, holds, latency, done
    initial begin
        logic          prev_rd, prev_valid, prev_stall, prev_done;
        logic [23:0]   h_data;
        logic [DB-1:0] h_x, h_y;
        int            rd_start;
        prev_rd = 0; prev_valid = 0; prev_stall = 0; prev_done = 0; rd_start = 0;
        h_data = '0; h_x = '0; h_y = '0;
        forever begin
            @(negedge clk_i);
            if (reset_i) begin
                prev_rd = 0; prev_valid = 0; prev_stall = 0; prev_done = 0;
            end else begin
                if (mem_rd_en_o) begin
                    reads_seen++;
                    if (!prev_rd) rd_start = cyc;
                    if (rd_q.size() == 0) begin
                        check("unexpected_read", {40'd0, mem_addr_o}, 64'hFFFF_FFFF);
                    end else begin
                        check("rd_addr", {40'd0, mem_addr_o}, {40'd0, rd_q.pop_front()});
                    end
                end
                if (pix_valid_o) check("rd_en_in_present", {63'd0, mem_rd_en_o}, 64'd0);
                if (pix_valid_o && !prev_valid) check("valid_latency", 64'(cyc - rd_start), 64'd4);
                if (prev_stall) begin
                    check("hold_valid", {63'd0, pix_valid_o}, 64'd1);
                    check("hold_data", {40'd0, pix_data_o}, {40'd0, h_data});
                    check("hold_xy", {40'd0, pix_x_o, pix_y_o}, {40'd0, h_x, h_y});
                end
                if (pix_valid_o && pix_ready_i) begin
                    if (pix_q.size() == 0) begin
                        check("unexpected_pixel", {40'd0, pix_data_o}, 64'hFFFF_FFFF);
                    end else begin
                        pix_t e;
                        e = pix_q.pop_front();
                        check("pix_data", {40'd0, pix_data_o}, {40'd0, e.data});
                        check("pix_xy", {40'd0, pix_x_o, pix_y_o}, {40'd0, e.x, e.y});
                        check("pix_tags", {61'd0, sof_o, eol_o, eof_o}, {61'd0, e.sof, e.eol, e.eof});
                        if (e.eof) last_hs_cyc = cyc;
                    end
                end
                if (done_o) begin
                    check("done_single", {63'd0, prev_done}, 64'd0);
                    check("done_busy_low", {63'd0, busy_o}, 64'd0);
                    if (exp_done == 0) begin
                        check("unexpected_done", 64'd1, 64'd0);
                    end else begin
                        if (exp_done == 1) check("done_after_hs", 64'(cyc - last_hs_cyc), 64'd1);
                        exp_done = 0;
                    end
                end
                prev_stall = pix_valid_o && !pix_ready_i;
                h_data = pix_data_o; h_x = pix_x_o; h_y = pix_y_o;
                prev_rd = mem_rd_en_o;
                prev_valid = pix_valid_o;
                prev_done = done_o;
            end
        end
    end

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done_o && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) check({name, "_timeout"}, 64'd1, 64'd0);
        tick();
    endtask

    // Issue one frame; poke pulses start with other dims while the frame is in flight
    task automatic run_frame(input int w, input int h, input bit poke);
        int rs;
        tick();
        rs = reads_seen;
        if (w == 0 || h == 0) exp_done = 2;
        else begin
            exp_done = 1;
            model_frame(w, h);
        end
        width_i = DB'(w); height_i = DB'(h); start_i = 1'b1;
        tick();
        start_i = 1'b0;
        if (poke) begin
            repeat (6) tick();
            width_i = 5; height_i = 3; start_i = 1'b1;
            tick();
            start_i = 1'b0;
        end
        wait_done("frame");
        check("frame_pixels_left", 64'(pix_q.size()), 64'd0);
        check("frame_reads_left", 64'(rd_q.size()), 64'd0);
        check("done_consumed", 64'(exp_done), 64'd0);
        if (w == 0 || h == 0) check("degenerate_reads", 64'(reads_seen - rs), 64'd0);
    endtask

    initial begin
        reset_i = 1'b1; start_i = 1'b0; width_i = '0; height_i = '0; exp_done = 0;
        repeat (3) tick();
        check("rst_rd_en", {63'd0, mem_rd_en_o}, 64'd0);
        check("rst_addr", {40'd0, mem_addr_o}, 64'd0);
        check("rst_valid", {63'd0, pix_valid_o}, 64'd0);
        check("rst_flags", {59'd0, sof_o, eol_o, eof_o, busy_o, done_o}, 64'd0);
        check("rst_xy", {40'd0, pix_x_o, pix_y_o}, 64'd0);
        reset_i = 1'b0;

        // 2x2, 3x1, 4x2, 1x1 with ready held high
        ready_mode = 0;
        run_frame(2, 2, 0);
        run_frame(3, 1, 0);
        run_frame(4, 2, 0);
        run_frame(1, 1, 0);

        // explicit byte packing at the frame origin
        tick();
        exp_done = 1;
        model_frame(1, 1);
        width_i = 1; height_i = 1; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        while (!pix_valid_o && cyc < 90000) tick();
        check("origin_pixel", {40'd0, pix_data_o}, 64'h030201);
        wait_done("origin");

        // stall 3 cycles per pixel
        ready_mode = 2;
        run_frame(3, 2, 0);

        // degenerate frames and start while busy
        ready_mode = 0;
        run_frame(0, 4, 0);
        run_frame(5, 0, 0);
        run_frame(3, 2, 1);

        // mid-frame reset during the reads of pixel (1,1)
        tick();
        exp_done = 1;
        model_frame(2, 2);
        width_i = 2; height_i = 2; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        begin
            int n;
            n = 0;
            while (!(mem_rd_en_o && mem_addr_o == 24'd11) && n < 200) begin
                tick();
                n++;
            end
            if (n >= 200) check("abort_wait_timeout", 64'd1, 64'd0);
        end
        reset_i = 1'b1;
        tick();
        check("abort_rd_en", {63'd0, mem_rd_en_o}, 64'd0);
        check("abort_addr", {40'd0, mem_addr_o}, 64'd0);
        check("abort_valid", {63'd0, pix_valid_o}, 64'd0);
        check("abort_flags", {59'd0, sof_o, eol_o, eof_o, busy_o, done_o}, 64'd0);
        pix_q.delete();
        rd_q.delete();
        exp_done = 0;
        reset_i = 1'b0;
        run_frame(2, 2, 0);

        // randomized frames with random backpressure
        ready_mode = 1;
        for (int i = 0; i < 8; i++) begin
            run_frame(int'($urandom_range(1, 9)), int'($urandom_range(1, 4)), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
